// File: rtl/rr_priority_encoder.sv
// Registered N-to-log2(N) priority encoder with valid/ready on both sides.
// MODE=0 picks the lowest set bit; MODE=1 scans round-robin from a rotating
// pointer so that repeated identical requests are served fairly.
module rr_priority_encoder #(
    parameter int N    = 8,
    parameter int W    = $clog2(N),
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] data,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] index,
    output logic         zero,
    output logic         multi
);

    localparam logic [W:0]   N_V  = (W+1)'(N);
    localparam logic [W-1:0] N_M1 = W'(N-1);

    logic         out_valid_q;
    logic [W-1:0] index_q, index_d;
    logic         zero_q, zero_d;
    logic         multi_q, multi_d;
    logic [W-1:0] ptr_q;
    logic [N-1:0] data_m;
    logic [N-1:0] rot;
    logic [W-1:0] k;
    logic [W:0]   sum;
    logic         in_acc;

    // Masking data keeps an undriven bus from reaching the encode logic.
    assign data_m   = in_valid ? data : '0;
    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign in_acc   = in_valid && in_ready;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then undo the
    // rotation modulo N (works for non-power-of-2 N as ptr < N always).
    always_comb begin
        rot = N'({data_m, data_m} >> ptr_q);
        k   = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (rot[i]) k = W'(i);
        end
        sum = {1'b0, ptr_q} + {1'b0, k};
        if (sum >= N_V) sum = sum - N_V;
        zero_d  = ~|data_m;
        multi_d = |(data_m & (data_m - 1'b1));
        index_d = zero_d ? '0 : sum[W-1:0];
    end

    generate
        if (MODE == 1) begin : g_rr
            logic [W-1:0] ptr_d;
            assign ptr_d = (index_d == N_M1) ? '0 : index_d + 1'b1;
            // Pointer advances past the granted bit; an empty vector leaves it alone.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                  ptr_q <= '0;
                else if (in_acc && !zero_d) ptr_q <= ptr_d;
            end
        end else begin : g_fixed
            assign ptr_q = '0;
        end
    endgenerate

    // Result registers load on input accept only; out_valid tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            index_q     <= '0;
            zero_q      <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            if (in_acc) begin
                index_q <= index_d;
                zero_q  <= zero_d;
                multi_q <= multi_d;
            end
            if (in_acc)         out_valid_q <= 1'b1;
            else if (out_ready) out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign index     = index_q;
    assign zero      = zero_q;
    assign multi     = multi_q;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed bench for rr_priority_encoder: fixed N=8, round-robin N=8, round-robin N=5.
module tb_rr_priority_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // fixed-priority, N=8
    logic       f_iv = 0, f_ir, f_ov, f_or = 0, f_z, f_m;
    logic [7:0] f_d = '0;
    logic [2:0] f_idx;
    // round-robin, N=8
    logic       r_iv = 0, r_ir, r_ov, r_or = 0, r_z, r_m;
    logic [7:0] r_d = '0;
    logic [2:0] r_idx;
    // round-robin, N=5
    logic       p_iv = 0, p_ir, p_ov, p_or = 0, p_z, p_m;
    logic [4:0] p_d = '0;
    logic [2:0] p_idx;

    rr_priority_encoder #(.N(8), .MODE(0)) u_f (
        .clk(clk), .rst(rst), .in_valid(f_iv), .data(f_d), .in_ready(f_ir),
        .out_valid(f_ov), .out_ready(f_or), .index(f_idx), .zero(f_z), .multi(f_m));
    rr_priority_encoder #(.N(8), .MODE(1)) u_r (
        .clk(clk), .rst(rst), .in_valid(r_iv), .data(r_d), .in_ready(r_ir),
        .out_valid(r_ov), .out_ready(r_or), .index(r_idx), .zero(r_z), .multi(r_m));
    rr_priority_encoder #(.N(5), .MODE(1)) u_p (
        .clk(clk), .rst(rst), .in_valid(p_iv), .data(p_d), .in_ready(p_ir),
        .out_valid(p_ov), .out_ready(p_or), .index(p_idx), .zero(p_z), .multi(p_m));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        checks++; if ({f_ov, f_idx, f_z, f_m, f_ir} !== 7'd0) begin errors++; $display("FAIL reset_f got %b want 0", {f_ov, f_idx, f_z, f_m, f_ir}); end
        checks++; if ({r_ov, r_idx, r_z, r_m, r_ir} !== 7'd0) begin errors++; $display("FAIL reset_r got %b want 0", {r_ov, r_idx, r_z, r_m, r_ir}); end
        checks++; if (u_r.ptr_q !== 3'd0) begin errors++; $display("FAIL reset_ptr got %0d want 0", u_r.ptr_q); end
        rst = 1'b0;
        #1;
        checks++; if ({f_ir, r_ir, p_ir} !== 3'b111) begin errors++; $display("FAIL ready_after_reset got %b want 111", {f_ir, r_ir, p_ir}); end
    endtask

    task automatic test_fixed();
        f_d = 8'b0110_0000; f_iv = 1; f_or = 1;
        tick();
        checks++; if ({f_ov, f_idx, f_z, f_m} !== {1'b1, 3'd5, 1'b0, 1'b1}) begin errors++; $display("FAIL fixed_60 got ov%b idx%0d z%b m%b want ov1 idx5 z0 m1", f_ov, f_idx, f_z, f_m); end
        f_d = 8'h80;
        tick();
        checks++; if ({f_ov, f_idx, f_z, f_m} !== {1'b1, 3'd7, 1'b0, 1'b0}) begin errors++; $display("FAIL fixed_80 got ov%b idx%0d z%b m%b want ov1 idx7 z0 m0", f_ov, f_idx, f_z, f_m); end
        f_iv = 0; f_d = 8'hFF;
        tick();
        checks++; if ({f_ov, f_idx} !== {1'b0, 3'd7}) begin errors++; $display("FAIL fixed_drain got ov%b idx%0d want ov0 idx7", f_ov, f_idx); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_idx [5];
        logic [2:0] exp_ptr [5];
        exp_idx = '{3'd0, 3'd2, 3'd5, 3'd7, 3'd0};
        exp_ptr = '{3'd1, 3'd3, 3'd6, 3'd0, 3'd1};
        r_d = 8'hA5; r_iv = 1; r_or = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({r_ov, r_idx, r_m} !== {1'b1, exp_idx[i], 1'b1}) begin errors++; $display("FAIL rr_idx[%0d] got ov%b idx%0d m%b want ov1 idx%0d m1", i, r_ov, r_idx, r_m, exp_idx[i]); end
            checks++; if (u_r.ptr_q !== exp_ptr[i]) begin errors++; $display("FAIL rr_ptr[%0d] got %0d want %0d", i, u_r.ptr_q, exp_ptr[i]); end
        end
    endtask

    task automatic test_zero_vector();
        r_d = 8'h04;
        tick();
        checks++; if ({r_idx, u_r.ptr_q} !== {3'd2, 3'd3}) begin errors++; $display("FAIL rr_set_ptr got idx%0d ptr%0d want idx2 ptr3", r_idx, u_r.ptr_q); end
        r_d = 8'h00;
        tick();
        checks++; if ({r_ov, r_idx, r_z, r_m} !== {1'b1, 3'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL zero_vec got ov%b idx%0d z%b m%b want ov1 idx0 z1 m0", r_ov, r_idx, r_z, r_m); end
        checks++; if (u_r.ptr_q !== 3'd3) begin errors++; $display("FAIL zero_ptr got %0d want 3", u_r.ptr_q); end
        r_iv = 0;
        tick();
    endtask

    task automatic test_backpressure();
        f_d = 8'h04; f_iv = 1; f_or = 0;
        tick();
        checks++; if ({f_ov, f_idx} !== {1'b1, 3'd2}) begin errors++; $display("FAIL bp_load got ov%b idx%0d want ov1 idx2", f_ov, f_idx); end
        f_d = 8'h80;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({f_ir, f_ov, f_idx} !== {1'b0, 1'b1, 3'd2}) begin errors++; $display("FAIL bp_stall[%0d] got ir%b ov%b idx%0d want ir0 ov1 idx2", i, f_ir, f_ov, f_idx); end
            tick();
        end
        f_or = 1;
        #1;
        checks++; if (f_ir !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", f_ir); end
        tick();
        checks++; if ({f_ov, f_idx} !== {1'b1, 3'd7}) begin errors++; $display("FAIL bp_b2b got ov%b idx%0d want ov1 idx7", f_ov, f_idx); end
        f_iv = 0;
        tick();
        checks++; if (f_ov !== 1'b0) begin errors++; $display("FAIL bp_drain got ov%b want 0", f_ov); end
    endtask

    task automatic test_non_pow2();
        p_d = 5'b00001; p_iv = 1; p_or = 1;
        tick();
        checks++; if ({p_idx, u_p.ptr_q} !== {3'd0, 3'd1}) begin errors++; $display("FAIL np2_set got idx%0d ptr%0d want idx0 ptr1", p_idx, u_p.ptr_q); end
        p_d = 5'b10001;
        tick();
        checks++; if ({p_idx, u_p.ptr_q, p_m} !== {3'd4, 3'd0, 1'b1}) begin errors++; $display("FAIL np2_wrap got idx%0d ptr%0d m%b want idx4 ptr0 m1", p_idx, u_p.ptr_q, p_m); end
        tick();
        checks++; if ({p_idx, u_p.ptr_q} !== {3'd0, 3'd1}) begin errors++; $display("FAIL np2_next got idx%0d ptr%0d want idx0 ptr1", p_idx, u_p.ptr_q); end
        p_iv = 0;
        tick();
    endtask

    task automatic test_async_reset();
        r_d = 8'h40; r_iv = 1; r_or = 0;
        tick();
        r_iv = 0;
        tick();
        checks++; if ({r_ov, r_idx, u_r.ptr_q} !== {1'b1, 3'd6, 3'd7}) begin errors++; $display("FAIL ar_setup got ov%b idx%0d ptr%0d want ov1 idx6 ptr7", r_ov, r_idx, u_r.ptr_q); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({r_ov, r_idx, r_z, r_m, r_ir} !== 7'd0) begin errors++; $display("FAIL ar_clear got %b want 0", {r_ov, r_idx, r_z, r_m, r_ir}); end
        checks++; if (u_r.ptr_q !== 3'd0) begin errors++; $display("FAIL ar_ptr got %0d want 0", u_r.ptr_q); end
        #1 rst = 1'b0;
        r_d = 8'hFF; r_iv = 1; r_or = 1;
        tick();
        checks++; if ({r_ov, r_idx, r_m} !== {1'b1, 3'd0, 1'b1}) begin errors++; $display("FAIL ar_after got ov%b idx%0d m%b want ov1 idx0 m1", r_ov, r_idx, r_m); end
        r_iv = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_zero_vector();
        test_backpressure();
        test_non_pow2();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_priority_encoder.md
# rr_priority_encoder

Parametrised, registered N-to-log2(N) priority encoder with a valid/ready handshake on both sides and a selectable fixed-priority or round-robin mode. It generalises the combinational 4:2 encoder in the Combinational library to any input width. It adds a "no bit set" flag, a "multiple bits set" flag, and a rotating priority pointer, so one block serves both as a plain encoder and as a fair request-to-index arbiter front end.

## Interface
- N, default 8: number of request bits; legal range 2..256, need not be a power of two.
- W, default $clog2(N): index width; derived, not overridden.
- MODE, default 0: 0 = fixed priority (bit 0 highest), 1 = round-robin.

- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous and active-high.
- in_valid  input  1  data is presented.
- data  input  N  request vector.
- in_ready  output  1  block accepts data this cycle.
- out_valid  output  1  registered result is valid.
- out_ready  input  1  downstream accepts the result.
- index  output  W  encoded position of the selected bit.
- zero  output  1  accepted vector had no bit set.
- multi  output  1  accepted vector had two or more bits set.

## Operation
- Input acceptance: `in_ready = !rst && (!out_valid || out_ready)`. This is combinational and gives a one-deep pipeline with no bubble under continuous flow.
- Input accept: occurs when `in_valid && in_ready`.
- Output accept: occurs when `out_valid && out_ready`.
- Encoding in fixed mode (MODE=0): index is the lowest set bit of data.
- Encoding in round-robin mode (MODE=1): index is the first set bit found scanning from ptr upward to N-1, then wrapping from 0 up to ptr-1.
- ptr: internal, W bits, reset 0. It exists only when MODE=1; in MODE=0 it is held at 0.
- ptr update: on an input accept with data != 0, ptr <= index+1. If index = N-1, ptr <= 0. This wrap applies for non-power-of-2 N too.
- Zero vector: if data == 0, then index=0, zero=1, multi=0. out_valid still asserts and ptr is unchanged.
- multi: set to 1 when popcount(data) >= 2, independent of mode.
- Output registers (index, zero, multi) load only on an input accept. They hold their value otherwise, including while stalled.
- out_valid update:
  - Set on an input accept.
  - Cleared on an output accept with no simultaneous input accept.
  - Stays 1 when an output accept and an input accept occur in the same cycle; the new result replaces the old one.
- Bits of data are ignored when in_valid=0. No X on data may propagate when in_valid=0.

## Timing
- Reset values: out_valid=0, index=0, zero=0, multi=0, ptr=0, in_ready=0. in_ready rises in the first cycle after rst deasserts.
- Latency: 1 cycle. A result is visible on the edge after the input accept.
- Throughput: 1 result per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, in_ready=0 and all outputs hold stable.
- Reset mid-operation: all outputs and ptr clear immediately and asynchronously. A pending result is discarded, not replayed.
- The encode path is combinational from data and ptr to the output registers. There is no multi-cycle path.

## Test plan
- Fixed mode, N=8, out_ready=1, data=8'b0110_0000 -> next cycle index=5, multi=1, zero=0, out_valid=1.
- Round-robin fairness, N=8, MODE=1, data=8'b1010_0101 held for 5 accepts -> index sequence 0, 2, 5, 7, 0; ptr sequence 1, 3, 6, 0, 1 (wrap checked).
- Zero vector, data=0 with ptr=3 -> index=0, zero=1, multi=0, out_valid=1, ptr remains 3.
- Backpressure: result index=2 pending with out_ready=0 for 4 cycles, new in_valid with data=8'h80 -> in_ready=0, index holds 2. When out_ready=1, the same cycle accepts data=8'h80 and the next cycle shows index=7 with out_valid staying 1.
- Non-power-of-2, N=5, W=3, MODE=1, data=5'b10001, ptr=1 -> index=4 and ptr wraps to 0. Next accept of 5'b10001 -> index=0, ptr=1.
- Async reset asserted mid-stall with out_valid=1 and index=6 -> outputs zero and in_ready=0 without a clock edge. After release, ptr=0, so data=8'hFF yields index=0.
